// File: rtl/key_window_sequencer.sv
// ---------------------------------------------------------------------------
// key_window_sequencer
//
// Purpose:
//    Key source for a time-keyed locked FSM. Six key slots are written by
//    software while idle. Once armed, the block waits for the start of the
//    next 0..29 period and then presents the key of the current 5-cycle
//    window on key_out. The period counter mirrors the consumer's counter
//    and uses the same reset net, so both stay cycle-aligned. All state
//    updates happen on the falling edge of clk, as in the consumer.
//
// Ports:
//    clk        in   1      clock, registers update on the falling edge
//    rst        in   1      asynchronous active-high reset
//    load_en    in   1      write request for one key slot
//    load_idx   in   3      slot index 0..NUM_WIN-1
//    load_key   in   KEY_W  key data, bit i drives consumer keyinput i
//    cfg_lock   in   1      sticky write protect, cleared only by rst
//    arm        in   1      request start of key delivery
//    halt       in   1      stop delivery and return to IDLE
//    key_out    out  KEY_W  key presented to the consumer
//    cnt        out  6      period counter 0..PERIOD-1
//    win_idx    out  3      current window, cnt / WIN_LEN
//    running    out  1      high while keys are being delivered
//    keys_ready out  1      every slot written since reset
//    load_err   out  1      one-cycle pulse after a rejected write
// ---------------------------------------------------------------------------
module key_window_sequencer #(
    parameter int KEY_W   = 18,
    parameter int NUM_WIN = 6,
    parameter int WIN_LEN = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [2:0]       load_idx,
    input  logic [KEY_W-1:0] load_key,
    input  logic             cfg_lock,
    input  logic             arm,
    input  logic             halt,
    output logic [KEY_W-1:0] key_out,
    output logic [5:0]       cnt,
    output logic [2:0]       win_idx,
    output logic             running,
    output logic             keys_ready,
    output logic             load_err
);

    localparam int                 PERIOD    = NUM_WIN * WIN_LEN;
    localparam logic [5:0]         CNT_LAST  = 6'(PERIOD - 1);
    localparam logic [NUM_WIN-1:0] ALL_VALID = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [5:0]         r_cnt;
    logic [5:0]         w_cntNext;
    logic [2:0]         w_winIdx;
    logic [2:0]         w_winNext;
    logic [KEY_W-1:0]   r_slot [NUM_WIN];
    logic [NUM_WIN-1:0] r_validMask;
    logic               r_lock;
    logic               r_loadErr;
    logic [KEY_W-1:0]   r_keyOut;
    logic [KEY_W-1:0]   w_keyNext;
    logic               w_keysReady;
    logic               w_writeAccept;

    // Maps a counter value onto its window number. Written as a threshold
    // scan rather than a divide so it stays a small compare chain.
    function automatic logic [2:0] winOf(input logic [5:0] c);
        logic [2:0] w;
        w = '0;
        for (int i = 1; i < NUM_WIN; i++) begin
            if (int'(c) >= i * WIN_LEN) begin
                w = 3'(i);
            end
        end
        return w;
    endfunction

    // Counter successor and the window of both the current and the next
    // count. The next window is what key_out has to show after this edge.
    always_comb begin
        w_cntNext = (r_cnt == CNT_LAST) ? 6'd0 : r_cnt + 6'd1;
        w_winIdx  = winOf(r_cnt);
        w_winNext = winOf(w_cntNext);
    end

    // A write is taken only in IDLE with the lock still open before this
    // edge, so a write paired with cfg_lock in the same cycle still lands.
    always_comb begin
        w_keysReady   = (r_validMask == ALL_VALID);
        w_writeAccept = load_en && (r_state == ST_IDLE) && !r_lock &&
                        (int'(load_idx) < NUM_WIN);
    end

    // The period counter never pauses in any state; it must track the
    // consumer's free-running counter that shares this reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cntNext;
        end
    end

    // Next-state logic. halt wins over arm and over the period wrap. The
    // arm decision uses keys_ready from before any write in this cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!halt && arm && w_keysReady) begin
                    w_stateNext = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (halt) begin
                    w_stateNext = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // The key for the coming window is selected one edge ahead so that it
    // is stable for a whole cycle before the consumer samples it. Outside
    // RUN the key is forced to zero, steering the consumer into its trap.
    always_comb begin
        w_keyNext = '0;
        if (w_stateNext == ST_RUN) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (w_winNext == 3'(i)) begin
                    w_keyNext = r_slot[i];
                end
            end
        end
    end

    // State register and registered key output.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_keyOut <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_keyOut <= w_keyNext;
        end
    end

    // Key storage, valid mask, sticky lock and the rejected-write pulse.
    // Reset wipes every key, so software has to reload after any reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                r_slot[i] <= '0;
            end
            r_validMask <= '0;
            r_lock      <= 1'b0;
            r_loadErr   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (w_writeAccept && (load_idx == 3'(i))) begin
                    r_slot[i]      <= load_key;
                    r_validMask[i] <= 1'b1;
                end
            end
            if (cfg_lock) begin
                r_lock <= 1'b1;
            end
            r_loadErr <= load_en && !w_writeAccept;
        end
    end

    assign key_out    = r_keyOut;
    assign cnt        = r_cnt;
    assign win_idx    = w_winIdx;
    assign running    = (r_state == ST_RUN);
    assign keys_ready = w_keysReady;
    assign load_err   = r_loadErr;

endmodule

// File: tb/tb_key_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_key_window_sequencer
//
// Purpose:
//    Directed bench for key_window_sequencer. A bench-side counter stands in
//    for the consumer's counter and is compared against cnt and win_idx on
//    every cycle. Key delivery is compared against the bench's own copy of
//    the loaded slot contents.
// ---------------------------------------------------------------------------
module tb_key_window_sequencer;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [2:0]  load_idx;
    logic [17:0] load_key;
    logic        cfg_lock;
    logic        arm;
    logic        halt;
    logic [17:0] key_out;
    logic [5:0]  cnt;
    logic [2:0]  win_idx;
    logic        running;
    logic        keys_ready;
    logic        load_err;

    int          total;
    int          bad;
    int          mCnt;
    logic [17:0] mSlot [6];

    key_window_sequencer #(
        .KEY_W   (18),
        .NUM_WIN (6),
        .WIN_LEN (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_idx   (load_idx),
        .load_key   (load_key),
        .cfg_lock   (cfg_lock),
        .arm        (arm),
        .halt       (halt),
        .key_out    (key_out),
        .cnt        (cnt),
        .win_idx    (win_idx),
        .running    (running),
        .keys_ready (keys_ready),
        .load_err   (load_err)
    );

    // Free-running clock; the design's active edge is the falling one.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the flow ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, lets one falling edge pass, advances the
    // consumer-counter model and checks the counter outputs against it.
    task automatic applyStimulus(input logic le, input logic [2:0] idx,
                                 input logic [17:0] key, input logic lk,
                                 input logic ar, input logic hl);
        load_en  = le;
        load_idx = idx;
        load_key = key;
        cfg_lock = lk;
        arm      = ar;
        halt     = hl;
        @(negedge clk);
        #1;
        mCnt = (mCnt == 29) ? 0 : mCnt + 1;
        checkOutput("cnt", 32'(cnt), 32'(mCnt));
        checkOutput("win_idx", 32'(win_idx), 32'(mCnt / 5));
        load_en  = 1'b0;
        load_idx = '0;
        load_key = '0;
        cfg_lock = 1'b0;
        arm      = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Steps until the model counter reads the target (bounded).
    task automatic waitCnt(input int target);
        for (int n = 0; n < 40 && mCnt != target; n++) begin
            idleCycle();
        end
        checkOutput("waitCnt", 32'(mCnt), 32'(target));
    endtask

    // After an arm: no delivery until the 29->0 edge, then slot 0.
    task automatic waitRun();
        for (int n = 0; n < 40 && mCnt != 29; n++) begin
            idleCycle();
            checkOutput("armed_running", 32'(running), 32'd0);
            checkOutput("armed_key", 32'(key_out), 32'd0);
        end
        idleCycle();
        checkOutput("start_running", 32'(running), 32'd1);
        checkOutput("start_key", 32'(key_out), 32'(mSlot[0]));
    endtask

    // One full period of delivery checked against the stored keys.
    task automatic runPass(input string tag);
        for (int n = 0; n < 30; n++) begin
            idleCycle();
            checkOutput({tag, "_running"}, 32'(running), 32'd1);
            checkOutput({tag, "_key"}, 32'(key_out), 32'(mSlot[mCnt / 5]));
        end
    endtask

    task automatic loadSlot(input int idx);
        applyStimulus(1'b1, 3'(idx), mSlot[idx], 1'b0, 1'b0, 1'b0);
        checkOutput("load_ok_err", 32'(load_err), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mCnt     = 0;
        load_en  = 1'b0;
        load_idx = '0;
        load_key = '0;
        cfg_lock = 1'b0;
        arm      = 1'b0;
        halt     = 1'b0;
        mSlot[0] = 18'h20E5D;
        mSlot[1] = 18'h11111;
        mSlot[2] = 18'h22222;
        mSlot[3] = 18'h33333;
        mSlot[4] = 18'h0ABCD;
        mSlot[5] = 18'h3FFFF;

        // Reset values while reset is held.
        rst = 1'b0;
        #1 rst = 1'b1;
        #12;
        checkOutput("rst_cnt", 32'(cnt), 32'd0);
        checkOutput("rst_win", 32'(win_idx), 32'd0);
        checkOutput("rst_key", 32'(key_out), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_ready", 32'(keys_ready), 32'd0);
        checkOutput("rst_err", 32'(load_err), 32'd0);
        #2 rst = 1'b0;

        // Partial load: arm must be ignored.
        for (int i = 0; i < 5; i++) begin
            loadSlot(i);
        end
        checkOutput("partial_ready", 32'(keys_ready), 32'd0);
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b0);
        waitCnt(29);
        idleCycle();
        checkOutput("partial_running", 32'(running), 32'd0);
        checkOutput("partial_key", 32'(key_out), 32'd0);

        // Complete the set and arm at cnt=12.
        loadSlot(5);
        checkOutput("full_ready", 32'(keys_ready), 32'd1);
        waitCnt(12);
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b0);
        waitRun();
        runPass("run1");

        // Write attempt while running is rejected.
        applyStimulus(1'b1, 3'd2, 18'h00000, 1'b0, 1'b0, 1'b0);
        checkOutput("run_write_err", 32'(load_err), 32'd1);
        idleCycle();
        checkOutput("run_write_err_clr", 32'(load_err), 32'd0);
        runPass("run2");

        // halt at cnt=17; counter keeps going.
        waitCnt(17);
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("halt_running", 32'(running), 32'd0);
        checkOutput("halt_key", 32'(key_out), 32'd0);
        idleCycle();
        checkOutput("halt_key2", 32'(key_out), 32'd0);

        // Out-of-range index rejected in IDLE.
        applyStimulus(1'b1, 3'd6, 18'h3FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("idx6_err", 32'(load_err), 32'd1);
        idleCycle();
        checkOutput("idx6_err_clr", 32'(load_err), 32'd0);
        checkOutput("idx6_ready", 32'(keys_ready), 32'd1);

        // Re-arm resumes at the next wrap with unchanged slots.
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b0);
        waitRun();
        runPass("run3");

        // Lock, then a write to slot 3 is refused and the old key stays.
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("halt2_running", 32'(running), 32'd0);
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd3, 18'h15555, 1'b0, 1'b0, 1'b0);
        checkOutput("lock_err", 32'(load_err), 32'd1);
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b0);
        waitRun();
        runPass("run4");

        // Asynchronous reset at cnt=22 in RUN.
        waitCnt(22);
        checkOutput("pre_rst_running", 32'(running), 32'd1);
        rst = 1'b1;
        #2;
        checkOutput("arst_cnt", 32'(cnt), 32'd0);
        checkOutput("arst_key", 32'(key_out), 32'd0);
        checkOutput("arst_ready", 32'(keys_ready), 32'd0);
        checkOutput("arst_running", 32'(running), 32'd0);
        mCnt = 0;
        #2 rst = 1'b0;

        // Lock is gone: reload with a new slot 3 and deliver it.
        mSlot[3] = 18'h15555;
        for (int i = 0; i < 6; i++) begin
            loadSlot(i);
        end
        checkOutput("reload_ready", 32'(keys_ready), 32'd1);
        applyStimulus(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b0);
        waitRun();
        runPass("run5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
